// File: rtl/reg_writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit_pkg
// Brief    : Shared types and constants for the register write-back unit.
// Revision : 1.0 - initial release
// ============================================================================
package reg_writeback_unit_pkg;

  localparam int NUM_REGS  = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] dst;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_unit_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Dual-push, single-pop circular buffer of pending register writes.
//            Entries are presented oldest-first (slot 0 is the head).
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push_a,
  input  logic [ADDR_W-1:0]        i_reg_a,
  input  logic [DATA_W-1:0]        i_data_a,
  input  logic                     i_push_b,
  input  logic [ADDR_W-1:0]        i_reg_b,
  input  logic [DATA_W-1:0]        i_data_b,
  input  logic                     i_pop,
  output logic [CNT_W-1:0]         o_count,
  output logic [DEPTH-1:0]         o_ent_valid,
  output logic [DEPTH*ADDR_W-1:0]  o_ent_reg,
  output logic [DEPTH*DATA_W-1:0]  o_ent_data
);

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_pop;
  logic [PTR_W-1:0]  w_slot_b;

  assign w_pop    = i_pop && (r_count != '0);
  // Push B lands behind push A when both are present, so A stays older.
  assign w_slot_b = r_wr_ptr + PTR_W'(i_push_a);
  assign o_count  = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_a) + PTR_W'(i_push_b);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push_a) + CNT_W'(i_push_b) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push_a) begin
      r_reg[r_wr_ptr]  <= i_reg_a;
      r_data[r_wr_ptr] <= i_data_a;
    end
    if (i_push_b) begin
      r_reg[w_slot_b]  <= i_reg_b;
      r_data[w_slot_b] <= i_data_b;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    logic [PTR_W-1:0] w_slot;
    assign w_slot                         = r_rd_ptr + PTR_W'(g);
    assign o_ent_valid[g]                 = CNT_W'(g) < r_count;
    assign o_ent_reg[g*ADDR_W +: ADDR_W]  = r_reg[w_slot];
    assign o_ent_data[g*DATA_W +: DATA_W] = r_data[w_slot];
  end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit
// Brief    : Orders ALU/load results into the register file write port and
//            publishes a pending-write mask. Optional macro WB_BYPASS_EN adds
//            a youngest-pending-value lookup port.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_reg,
  input  logic [DATA_W-1:0]    ld_data,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic                 reg_write_en,
  output logic [NUM_REGS-1:0]  busy_mask
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]    lookup_reg,
  output logic                 lookup_hit,
  output logic [DATA_W-1:0]    lookup_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]         w_count;
  logic [DEPTH-1:0]         w_ent_valid;
  logic [DEPTH*ADDR_W-1:0]  w_ent_reg;
  logic [DEPTH*DATA_W-1:0]  w_ent_data;
  logic                     w_alu_push;
  logic                     w_ld_push;
  logic                     w_pop;
  logic [ADDR_W-1:0]        w_head_reg;
  logic [DATA_W-1:0]        w_head_data;

  // Readiness is a function of the registered count only; a same-cycle pop
  // never makes room, which keeps the ready paths short.
  assign alu_ready = w_count < CNT_W'(DEPTH);
  assign ld_ready  = (w_count <= CNT_W'(DEPTH - 2)) ||
                     ((w_count == CNT_W'(DEPTH - 1)) && !alu_valid);

  // Writes to $zero handshake normally but are dropped here.
  assign w_alu_push = alu_valid && alu_ready && (alu_reg != ADDR_W'(REG_ZERO));
  assign w_ld_push  = ld_valid && ld_ready && (ld_reg != ADDR_W'(REG_ZERO));
  assign w_pop      = (w_count != '0);

  assign w_head_reg  = w_ent_reg[ADDR_W-1:0];
  assign w_head_data = w_ent_data[DATA_W-1:0];

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push_a    (w_alu_push),
    .i_reg_a     (alu_reg),
    .i_data_a    (alu_data),
    .i_push_b    (w_ld_push),
    .i_reg_b     (ld_reg),
    .i_data_b    (ld_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_ent_valid (w_ent_valid),
    .o_ent_reg   (w_ent_reg),
    .o_ent_data  (w_ent_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_reg    <= '0;
      write_data   <= '0;
      reg_write_en <= 1'b0;
    end else if (w_pop) begin
      write_reg    <= w_head_reg;
      write_data   <= w_head_data;
      reg_write_en <= 1'b1;
    end else begin
      reg_write_en <= 1'b0;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (reg_write_en && (write_reg == ADDR_W'(r))) begin
        busy_mask[r] = 1'b1;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ent_valid[k] && (w_ent_reg[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          busy_mask[r] = 1'b1;
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match is the value that will win.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (lookup_reg != ADDR_W'(REG_ZERO)) begin
      if (reg_write_en && (write_reg == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = write_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ent_valid[k] && (w_ent_reg[k*ADDR_W +: ADDR_W] == lookup_reg)) begin
          lookup_hit  = 1'b1;
          lookup_data = w_ent_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end
`else
  logic w_unused_ent_data;
  assign w_unused_ent_data = ^w_ent_data[DEPTH*DATA_W-1:DATA_W];
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_unit
// Brief    : Randomized self-checking bench against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_unit;
  import reg_writeback_unit_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_reg = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write_en;
  logic [31:0]       busy_mask;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] lookup_reg = '0;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
`endif

  reg_writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_reg       (ld_reg),
    .ld_data      (ld_data),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .reg_write_en (reg_write_en),
    .busy_mask    (busy_mask)
`ifdef WB_BYPASS_EN
    ,
    .lookup_reg   (lookup_reg),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the pending queue in acceptance order plus the write-port state.
  wb_entry_t   q[$];
  logic        m_en    = 1'b0;
  logic [4:0]  m_wreg  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_alu_ready();
    return q.size() < DEPTH;
  endfunction

  function automatic logic exp_ld_ready(input logic av);
    int n = q.size();
    return (n <= DEPTH - 2) || ((n == DEPTH - 1) && !av);
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].dst] = 1'b1;
    if (m_en) m[m_wreg] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic compare();
    chk("alu_ready", alu_ready, exp_alu_ready());
    chk("ld_ready", ld_ready, exp_ld_ready(alu_valid));
    chk("busy_mask", busy_mask, exp_mask());
    chk("reg_write_en", reg_write_en, m_en);
    chk("write_reg", write_reg, m_wreg);
    chk("write_data", write_data, m_wdata);
`ifdef WB_BYPASS_EN
    begin
      logic        hit = 1'b0;
      logic [31:0] val = '0;
      if (lookup_reg != 0) begin
        if (m_en && m_wreg == lookup_reg) begin hit = 1'b1; val = m_wdata; end
        foreach (q[i]) if (q[i].dst == lookup_reg) begin hit = 1'b1; val = q[i].data; end
      end
      chk("lookup_hit", lookup_hit, hit);
      chk("lookup_data", lookup_data, val);
    end
`endif
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      output logic a_acc, output logic l_acc);
    wb_entry_t e;
    @(negedge clk);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid  = lv; ld_reg  = lr; ld_data  = ld;
`ifdef WB_BYPASS_EN
    lookup_reg = ($urandom_range(0, 1) == 0) ? 5'(16 + $urandom_range(0, 3))
                                             : 5'($urandom_range(0, 31));
`endif
    #1 compare();
    a_acc = av && exp_alu_ready();
    l_acc = lv && exp_ld_ready(av);
    @(posedge clk);
    if (m_en) rf[m_wreg] = m_wdata;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_en = 1'b1; m_wreg = e.dst; m_wdata = e.data;
    end else begin
      m_en = 1'b0;
    end
    if (a_acc && ar != 0) q.push_back('{dst: ar, data: ad});
    if (l_acc && lr != 0) q.push_back('{dst: lr, data: ld});
    #1;
  endtask

  task automatic idle(input int n);
    logic a, l;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 15) == 0) return 5'd0;
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'(16 + $urandom_range(0, 3));
  endfunction

  initial begin
    logic        a, l;
    logic        pa_v, pl_v;
    logic [4:0]  pa_r, pl_r;
    logic [31:0] pa_d, pl_d;

    foreach (rf[i]) rf[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", reg_write_en, 0);
    chk("rst_wreg", write_reg, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_mask", busy_mask, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write: reg 8 <= 0x11
    step(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0, a, l);
    chk("single_busy8", busy_mask[8], 1);
    chk("single_en_early", reg_write_en, 0);
    idle(1);
    chk("single_en", reg_write_en, 1);
    chk("single_wreg", write_reg, 8);
    chk("single_wdata", write_data, 32'h11);
    chk("single_busy8_port", busy_mask[8], 1);
    idle(1);
    chk("single_en_drop", reg_write_en, 0);
    chk("single_busy8_clr", busy_mask[8], 0);

    // Simultaneous sources to reg 9: ALU 0xA older than load 0xB
    step(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, a, l);
    idle(1);
    chk("simul_first", write_data, 32'hA);
    idle(1);
    chk("simul_second", write_data, 32'hB);
    chk("simul_wreg", write_reg, 9);
    idle(2);
    chk("simul_rf9", rf[9], 32'hB);

    // Fill / backpressure
    step(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, a, l);
    step(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, a, l);
    chk("fill_ld_ready", ld_ready, 0);
    chk("fill_alu_ready", alu_ready, 1);
    step(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, a, l);
    chk("fill_ld_held", l, 0);
    step(1'b1, 5'd7, 32'h107, 1'b1, 5'd6, 32'h106, a, l);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h106, a, l);
    idle(8);

    // $zero write is accepted but never reaches the port
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, a, l);
    chk("zero_mask", busy_mask, 0);
    idle(1);
    chk("zero_en", reg_write_en, 0);
    idle(1);

`ifdef WB_BYPASS_EN
    // Two pending writes to reg 20: youngest value wins
    step(1'b1, 5'd20, 32'h3, 1'b1, 5'd20, 32'h4, a, l);
    lookup_reg = 5'd20;
    #1;
    chk("byp_hit20", lookup_hit, 1);
    chk("byp_data20", lookup_data, 32'h4);
    lookup_reg = 5'd21;
    #1;
    chk("byp_hit21", lookup_hit, 0);
    chk("byp_data21", lookup_data, 0);
    idle(4);
`endif

    // Asynchronous reset with three entries queued
    step(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, a, l);
    step(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, a, l);
    chk("arst_pre_en", reg_write_en, 1);
    @(negedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", reg_write_en, 0);
    chk("arst_mask", busy_mask, 0);
    chk("arst_wreg", write_reg, 0);
    chk("arst_wdata", write_data, 0);
    q.delete();
    m_en = 1'b0; m_wreg = '0; m_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Randomized traffic; producers hold a result until it is accepted
    pa_v = 1'b0; pl_v = 1'b0; a = 1'b1; l = 1'b1;
    pa_r = '0; pl_r = '0; pa_d = '0; pl_d = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!pa_v || a) begin
        pa_v = $urandom_range(0, 3) != 0;
        pa_r = pick_reg();
        pa_d = $urandom;
      end
      if (!pl_v || l) begin
        pl_v = $urandom_range(0, 1) != 0;
        pl_r = pick_reg();
        pl_d = $urandom;
      end
      step(pa_v, pa_r, pa_d, pl_v, pl_r, pl_d, a, l);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
